// File: rtl/cpu_state_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dbg_pkg
// Description : Shared types and frame layout constants for the CPU state
//               dumper. The frame is a header word, four counter/PC words,
//               the register file and a window of data memory.
// Contents    : state_t FSM encoding, HDR_TAG, frame index bases, default
//               sizes and a frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CNT  = 3'd2,
    REG  = 3'd3,
    MEM  = 3'd4
  } state_t;

  localparam int         DEF_NUM_REGS  = 32;
  localparam int         DEF_MEM_WORDS = 8;
  localparam int         DEF_CNT_W     = 32;
  localparam logic [7:0] HDR_TAG       = 8'hA5;

  // Frame word index bases: 0 is the header, then cyc/stl/fls/pc.
  localparam int CNT_BASE  = 1;
  localparam int REG_BASE  = 5;
  localparam int MEM_BASE  = REG_BASE + DEF_NUM_REGS;
  localparam int FRAME_LEN = MEM_BASE + DEF_MEM_WORDS;

  function automatic int frame_len(input int nregs, input int mwords);
    return REG_BASE + nregs + mwords;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_state_dumper_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_state_dumper_if
// Description : Bus bundle of the state dumper: the valid/ready trace link to
//               the off-chip sink plus the debug read ports into the register
//               file and data memory.
// Modports    : master - dumper side (drives tx_*_o, reg_addr_o, mem_addr_o)
//               slave  - sink / CPU side (drives tx_ready_i, *_data_i)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_state_dumper_if;

  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] tx_data_o;
  logic        tx_last_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;

  modport master (
    output tx_valid_o, tx_data_o, tx_last_o, reg_addr_o, mem_addr_o,
    input  tx_ready_i, reg_data_i, mem_data_i
  );

  modport slave (
    input  tx_valid_o, tx_data_o, tx_last_o, reg_addr_o, mem_addr_o,
    output tx_ready_i, reg_data_i, mem_data_i
  );

endinterface
`default_nettype wire

// File: rtl/cpu_state_dumper_dbg_event_counters.sv
`default_nettype none
// ============================================================================
// Module      : dbg_event_counters
// Description : Free-running cycle / stall / flush event counters (advance
//               only while the CPU runs) plus the snapshot latch that freezes
//               them and the PC when a frame is accepted. Snapshots are held
//               as 32-bit words, zero-extended or truncated from CNT_W.
// Ports       : clk, rst_n (async active-low), i_start, i_stall, i_flush,
//               i_pc, i_capture -> o_cyc_snap, o_stl_snap, o_fls_snap, o_pc_snap
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_event_counters #(
  parameter int CNT_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_start,
  input  wire logic        i_stall,
  input  wire logic        i_flush,
  input  wire logic [31:0] i_pc,
  input  wire logic        i_capture,
  output logic      [31:0] o_cyc_snap,
  output logic      [31:0] o_stl_snap,
  output logic      [31:0] o_fls_snap,
  output logic      [31:0] o_pc_snap
);

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_stl;
  logic [CNT_W-1:0] r_fls;
  logic [31:0]      r_cyc_snap;
  logic [31:0]      r_stl_snap;
  logic [31:0]      r_fls_snap;
  logic [31:0]      r_pc_snap;
  logic [31:0]      w_cyc32;
  logic [31:0]      w_stl32;
  logic [31:0]      w_fls32;

  generate
    if (CNT_W >= 32) begin : g_trunc
      assign w_cyc32 = r_cyc[31:0];
      assign w_stl32 = r_stl[31:0];
      assign w_fls32 = r_fls[31:0];
    end else begin : g_zext
      assign w_cyc32 = {{(32-CNT_W){1'b0}}, r_cyc};
      assign w_stl32 = {{(32-CNT_W){1'b0}}, r_stl};
      assign w_fls32 = {{(32-CNT_W){1'b0}}, r_fls};
    end
  endgenerate

  // The snapshot takes the counter values as they stand before this edge's
  // increment, so the frame reports the cycles completed prior to the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc      <= '0;
      r_stl      <= '0;
      r_fls      <= '0;
      r_cyc_snap <= '0;
      r_stl_snap <= '0;
      r_fls_snap <= '0;
      r_pc_snap  <= '0;
    end else begin
      r_cyc <= r_cyc + CNT_W'(i_start);
      r_stl <= r_stl + CNT_W'(i_start & i_stall);
      r_fls <= r_fls + CNT_W'(i_start & i_flush);
      if (i_capture) begin
        r_cyc_snap <= w_cyc32;
        r_stl_snap <= w_stl32;
        r_fls_snap <= w_fls32;
        r_pc_snap  <= i_pc;
      end
    end
  end

  assign o_cyc_snap = r_cyc_snap;
  assign o_stl_snap = r_stl_snap;
  assign o_fls_snap = r_fls_snap;
  assign o_pc_snap  = r_pc_snap;

endmodule
`default_nettype wire

// File: rtl/cpu_state_dumper.sv
`default_nettype none
// ============================================================================
// Module      : cpu_state_dumper
// Description : Streams one fixed-length CPU state frame (header, counters,
//               PC, x0..x(NUM_REGS-1), MEM_WORDS data words) per accepted
//               snapshot request over a valid/ready link. Registers and memory
//               are read live through debug ports while each word is loaded.
// Ports       : clk_i, rst_i (async active-low), start_i, stall_i, flush_i,
//               pc_i, snap_i, bus (master: tx link + debug read ports),
//               busy_o (frame in progress), overrun_o (sticky dropped snap)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_state_dumper #(
  parameter int         NUM_REGS  = cpu_dbg_pkg::DEF_NUM_REGS,
  parameter int         MEM_WORDS = cpu_dbg_pkg::DEF_MEM_WORDS,
  parameter int         CNT_W     = cpu_dbg_pkg::DEF_CNT_W,
  parameter logic [7:0] HDR_TAG   = cpu_dbg_pkg::HDR_TAG
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        start_i,
  input  wire logic        stall_i,
  input  wire logic        flush_i,
  input  wire logic [31:0] pc_i,
  input  wire logic        snap_i,
  cpu_state_dumper_if.master bus,
  output logic             busy_o,
  output logic             overrun_o
);

  import cpu_dbg_pkg::*;

  localparam int c_MEM_BASE  = REG_BASE + NUM_REGS;
  localparam int c_FRAME_LEN = frame_len(NUM_REGS, MEM_WORDS);
  localparam int c_K_W       = $clog2(c_FRAME_LEN + 1);

  localparam logic [c_K_W-1:0] c_K_ONE      = c_K_W'(1);
  localparam logic [c_K_W-1:0] c_K_CYC      = c_K_W'(CNT_BASE);
  localparam logic [c_K_W-1:0] c_K_STL      = c_K_W'(CNT_BASE + 1);
  localparam logic [c_K_W-1:0] c_K_FLS      = c_K_W'(CNT_BASE + 2);
  localparam logic [c_K_W-1:0] c_K_PC       = c_K_W'(CNT_BASE + 3);
  localparam logic [c_K_W-1:0] c_K_REG      = c_K_W'(REG_BASE);
  localparam logic [c_K_W-1:0] c_K_REG_LAST = c_K_W'(c_MEM_BASE - 1);
  localparam logic [c_K_W-1:0] c_K_MEM      = c_K_W'(c_MEM_BASE);
  localparam logic [c_K_W-1:0] c_K_MEM_LAST = c_K_W'(c_FRAME_LEN - 1);
  localparam logic [c_K_W-1:0] c_K_END      = c_K_W'(c_FRAME_LEN);
  localparam logic [7:0]       c_LEN_BYTE   = 8'(c_FRAME_LEN);

  state_t           r_state;
  logic [c_K_W-1:0] r_k;
  logic             r_valid;
  logic             r_last;
  logic [31:0]      r_data;
  logic             r_busy;
  logic             r_overrun;

  logic             w_accept;
  logic             w_load;
  logic [31:0]      w_word;
  logic [31:0]      w_cyc_snap;
  logic [31:0]      w_stl_snap;
  logic [31:0]      w_fls_snap;
  logic [31:0]      w_pc_snap;

  assign w_accept = (r_state == IDLE) && snap_i;
  // The output register may take a new word whenever it is empty or its
  // current word is being consumed this cycle.
  assign w_load   = !r_valid || bus.tx_ready_i;

  dbg_event_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .i_start    (start_i),
    .i_stall    (stall_i),
    .i_flush    (flush_i),
    .i_pc       (pc_i),
    .i_capture  (w_accept),
    .o_cyc_snap (w_cyc_snap),
    .o_stl_snap (w_stl_snap),
    .o_fls_snap (w_fls_snap),
    .o_pc_snap  (w_pc_snap)
  );

  // r_k always names the next word to load, so the debug addresses point at
  // it for as long as the load is held off by back-pressure.
  assign bus.reg_addr_o = (r_state == REG) ? 5'(r_k - c_K_REG) : 5'd0;
  assign bus.mem_addr_o = (r_state == MEM && r_k != c_K_END) ?
                          (32'(r_k - c_K_MEM) << 2) : 32'd0;

  always_comb begin
    w_word = 32'd0;
    case (r_state)
      HDR: w_word = {HDR_TAG, c_LEN_BYTE, w_cyc_snap[15:0]};
      CNT: begin
        if (r_k == c_K_CYC)      w_word = w_cyc_snap;
        else if (r_k == c_K_STL) w_word = w_stl_snap;
        else if (r_k == c_K_FLS) w_word = w_fls_snap;
        else                     w_word = w_pc_snap;
      end
      REG:     w_word = bus.reg_data_i;
      MEM:     w_word = bus.mem_data_i;
      default: w_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (snap_i && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (snap_i) begin
            r_state <= HDR;
            r_busy  <= 1'b1;
            r_k     <= '0;
          end
        end
        HDR: begin
          if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_k     <= c_K_CYC;
            r_state <= CNT;
          end
        end
        CNT: begin
          if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_k     <= r_k + c_K_ONE;
            if (r_k == c_K_PC) begin
              r_state <= REG;
            end
          end
        end
        REG: begin
          if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_k     <= r_k + c_K_ONE;
            if (r_k == c_K_REG_LAST) begin
              r_state <= MEM;
            end
          end
        end
        MEM: begin
          if (r_k == c_K_END) begin
            // Last word is on the link; close the frame once it is taken.
            if (bus.tx_ready_i) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_k     <= '0;
              r_state <= IDLE;
            end
          end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_k     <= r_k + c_K_ONE;
            if (r_k == c_K_MEM_LAST) begin
              r_last <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_valid_o = r_valid;
  assign bus.tx_data_o  = r_data;
  assign bus.tx_last_o  = r_last;
  assign busy_o         = r_busy;
  assign overrun_o      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_state_dumper
// Description : Directed self-checking bench for cpu_state_dumper. A second
//               instance with 4-bit counters covers counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_state_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        snap = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        busy, overrun, busy4, overrun4;
  logic [31:0] regs [0:31];
  logic [7:0]  mem  [0:31];
  logic [4:0]  mi, mi4;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] got [0:63];
  int ngot, last_idx, nlast, nvalid, nunstable;
  bit done_ok;

  always #5 clk = ~clk;

  cpu_state_dumper_if bus ();
  cpu_state_dumper_if bus4 ();

  assign mi  = bus.mem_addr_o[4:0];
  assign mi4 = bus4.mem_addr_o[4:0];
  assign bus.reg_data_i  = regs[bus.reg_addr_o];
  assign bus.mem_data_i  = {mem[mi+5'd3], mem[mi+5'd2], mem[mi+5'd1], mem[mi]};
  assign bus4.reg_data_i = regs[bus4.reg_addr_o];
  assign bus4.mem_data_i = {mem[mi4+5'd3], mem[mi4+5'd2], mem[mi4+5'd1], mem[mi4]};
  assign bus4.tx_ready_i = 1'b1;

  cpu_state_dumper dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .snap_i(snap), .bus(bus), .busy_o(busy), .overrun_o(overrun)
  );

  cpu_state_dumper #(.CNT_W(4)) dut_w4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .snap_i(snap), .bus(bus4), .busy_o(busy4), .overrun_o(overrun4)
  );

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] c,
                                           input logic [31:0] s, input logic [31:0] f,
                                           input logic [31:0] p);
    int j;
    if (k == 0) return {8'hA5, 8'd45, c[15:0]};
    if (k == 1) return c;
    if (k == 2) return s;
    if (k == 3) return f;
    if (k == 4) return p;
    if (k <= 36) return regs[k-5];
    j = 4 * (k - 37);
    return {mem[j+3], mem[j+2], mem[j+1], mem[j]};
  endfunction

  function automatic int count_mismatch(input logic [31:0] c, input logic [31:0] s,
                                        input logic [31:0] f, input logic [31:0] p);
    int n = 0;
    for (int k = 0; k < 45; k++) if (got[k] !== exp_word(k, c, s, f, p)) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; snap = 1'b0;
    pc = 32'd0; bus.tx_ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Receives words until the tx_last handshake or the cycle budget runs out.
  task automatic collect(input bit toggle, input int budget);
    bit ph, hold, fin;
    logic [31:0] held;
    ngot = 0; last_idx = -1; nlast = 0; nvalid = 0; nunstable = 0; done_ok = 1'b0;
    ph = 1'b0; hold = 1'b0; held = '0;
    for (int t = 0; t < budget && !done_ok; t++) begin
      bus.tx_ready_i = toggle ? ph : 1'b1;
      ph = ~ph;
      fin = 1'b0;
      if (bus.tx_valid_o) begin
        nvalid++;
        if (hold && bus.tx_data_o !== held) nunstable++;
        if (bus.tx_ready_i) begin
          if (ngot < 64) got[ngot] = bus.tx_data_o;
          if (bus.tx_last_o) begin nlast++; last_idx = ngot; fin = 1'b1; end
          ngot++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = bus.tx_data_o;
        end
      end
      tick();
      if (fin) done_ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_total++; if (bus.tx_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.tx_valid_o); else n_pass++;
    n_total++; if (bus.tx_data_o !== 32'd0) $display("FAIL reset_data: got %h expected 0", bus.tx_data_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
    n_total++; if (bus.tx_last_o !== 1'b0) $display("FAIL reset_last: got %b expected 0", bus.tx_last_o); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; stall = (i == 1 || i == 4 || i == 8); tick();
    end
    start = 1'b0; stall = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL accept_busy: got %b expected 1", busy); else n_pass++;
    n_total++; if (bus.tx_valid_o !== 1'b0) $display("FAIL accept_valid: got %b expected 0", bus.tx_valid_o); else n_pass++;
    tick();
    n_total++; if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 32'hA52D000A)
      $display("FAIL first_word: got v=%b %h expected v=1 a52d000a", bus.tx_valid_o, bus.tx_data_o); else n_pass++;
    collect(1'b0, 60);
    n_total++; if (!done_ok || ngot != 45) $display("FAIL basic_len: got %0d words done=%b expected 45", ngot, done_ok); else n_pass++;
    n_total++; if (last_idx != 44 || nlast != 1) $display("FAIL basic_last: got idx %0d count %0d expected 44/1", last_idx, nlast); else n_pass++;
    n_total++; if (got[1] !== 32'd10) $display("FAIL basic_cyc: got %h expected 0000000a", got[1]); else n_pass++;
    n_total++; if (got[2] !== 32'd3) $display("FAIL basic_stl: got %h expected 00000003", got[2]); else n_pass++;
    n_total++; if (count_mismatch(32'd10, 32'd3, 32'd0, 32'd0) != 0)
      $display("FAIL basic_frame: got %0d bad words expected 0", count_mismatch(32'd10, 32'd3, 32'd0, 32'd0)); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b expected 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b expected 0", overrun); else n_pass++;
  endtask

  task automatic test_counters();
    logic [1:0] pat [0:5];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b00; pat[4] = 2'b11; pat[5] = 2'b00;
    do_reset();
    pc = 32'h0000_1234;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; {stall, flush} = pat[i]; tick();
    end
    start = 1'b0; stall = 1'b1; flush = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0; flush = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    pc = 32'hFFFF_FFFF;
    collect(1'b0, 60);
    n_total++; if (got[0] !== 32'hA52D0006) $display("FAIL cnt_hdr: got %h expected a52d0006", got[0]); else n_pass++;
    n_total++; if (got[1] !== 32'd6) $display("FAIL cnt_cyc: got %h expected 00000006", got[1]); else n_pass++;
    n_total++; if (got[2] !== 32'd2) $display("FAIL cnt_stl: got %h expected 00000002", got[2]); else n_pass++;
    n_total++; if (got[3] !== 32'd3) $display("FAIL cnt_fls: got %h expected 00000003", got[3]); else n_pass++;
    n_total++; if (got[4] !== 32'h1234) $display("FAIL cnt_pc: got %h expected 00001234", got[4]); else n_pass++;
  endtask

  task automatic test_regs_mem();
    int nz;
    do_reset();
    for (int i = 0; i < 32; i++) begin regs[i] = 32'd0; mem[i] = 8'd0; end
    regs[1] = 32'd5; regs[31] = 32'hDEADBEEF; mem[0] = 8'h05;
    snap = 1'b1; tick(); snap = 1'b0;
    collect(1'b0, 60);
    nz = 0;
    for (int k = 1; k < 45; k++) if (k != 6 && k != 36 && k != 37 && got[k] !== 32'd0) nz++;
    n_total++; if (got[6] !== 32'd5) $display("FAIL rm_x1: got %h expected 00000005", got[6]); else n_pass++;
    n_total++; if (got[36] !== 32'hDEADBEEF) $display("FAIL rm_x31: got %h expected deadbeef", got[36]); else n_pass++;
    n_total++; if (got[37] !== 32'd5) $display("FAIL rm_mem0: got %h expected 00000005", got[37]); else n_pass++;
    n_total++; if (nz != 0) $display("FAIL rm_zeros: got %0d nonzero words expected 0", nz); else n_pass++;
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 32; i++) begin regs[i] = 32'h1000_0000 + 32'(i * 3); mem[i] = 8'(i * 7 + 1); end
    snap = 1'b1; tick(); snap = 1'b0;
    collect(1'b1, 140);
    n_total++; if (!done_ok || ngot != 45 || last_idx != 44)
      $display("FAIL tog_len: got %0d words last %0d expected 45/44", ngot, last_idx); else n_pass++;
    n_total++; if (nvalid < 89 || nvalid > 90) $display("FAIL tog_cycles: got %0d expected 89..90", nvalid); else n_pass++;
    n_total++; if (nunstable != 0) $display("FAIL tog_stable: got %0d changes expected 0", nunstable); else n_pass++;
    n_total++; if (count_mismatch(32'd0, 32'd0, 32'd0, 32'd0) != 0)
      $display("FAIL tog_frame: got %0d bad words expected 0", count_mismatch(32'd0, 32'd0, 32'd0, 32'd0)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    snap = 1'b1;
    collect(1'b0, 60);
    n_total++; if (!done_ok || ngot != 45) $display("FAIL b2b_first: got %0d words expected 45", ngot); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_gap: got busy %b expected 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun: got %b expected 1", overrun); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_restart: got busy %b expected 1", busy); else n_pass++;
    collect(1'b0, 60);
    snap = 1'b0;
    n_total++; if (!done_ok || ngot != 45 || last_idx != 44)
      $display("FAIL b2b_second: got %0d words last %0d expected 45/44", ngot, last_idx); else n_pass++;
    n_total++; if (count_mismatch(32'd0, 32'd0, 32'd0, 32'd0) != 0)
      $display("FAIL b2b_frame: got %0d bad words expected 0", count_mismatch(32'd0, 32'd0, 32'd0, 32'd0)); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_no_queue: got busy %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin start = 1'b1; tick(); end
    start = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    bus.tx_ready_i = 1'b1;
    tick();
    n_total++; if (bus4.tx_valid_o !== 1'b1 || bus4.tx_data_o !== 32'hA52D0001)
      $display("FAIL wrap_hdr: got v=%b %h expected v=1 a52d0001", bus4.tx_valid_o, bus4.tx_data_o); else n_pass++;
    n_total++; if (bus.tx_data_o !== 32'hA52D0011) $display("FAIL wide_hdr: got %h expected a52d0011", bus.tx_data_o); else n_pass++;
    tick();
    n_total++; if (bus4.tx_data_o !== 32'd1) $display("FAIL wrap_cyc: got %h expected 00000001", bus4.tx_data_o); else n_pass++;
    n_total++; if (bus.tx_data_o !== 32'd17) $display("FAIL wide_cyc: got %h expected 00000011", bus.tx_data_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int hs;
    bit hit;
    do_reset();
    for (int i = 0; i < 5; i++) begin start = 1'b1; tick(); end
    start = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    bus.tx_ready_i = 1'b1;
    hs = 0; hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      if (bus.tx_valid_o && hs == 20) hit = 1'b1;
      else begin
        if (bus.tx_valid_o && bus.tx_ready_i) hs++;
        tick();
      end
    end
    n_total++; if (!hit || bus.tx_data_o !== exp_word(20, 32'd5, 32'd0, 32'd0, 32'd0))
      $display("FAIL mid_word20: got hit=%b %h expected hit=1 %h", hit, bus.tx_data_o, exp_word(20, 32'd5, 32'd0, 32'd0, 32'd0)); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.tx_valid_o !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_async: got v=%b busy=%b expected 0/0", bus.tx_valid_o, busy); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (bus.tx_valid_o !== 1'b0) $display("FAIL mid_no_tail: got v=%b expected 0", bus.tx_valid_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin start = 1'b1; tick(); end
    start = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    collect(1'b0, 60);
    n_total++; if (!done_ok || ngot != 45 || last_idx != 44)
      $display("FAIL mid_len: got %0d words last %0d expected 45/44", ngot, last_idx); else n_pass++;
    n_total++; if (got[1] !== 32'd3) $display("FAIL mid_cyc: got %h expected 00000003", got[1]); else n_pass++;
    n_total++; if (count_mismatch(32'd3, 32'd0, 32'd0, 32'd0) != 0)
      $display("FAIL mid_frame: got %0d bad words expected 0", count_mismatch(32'd3, 32'd0, 32'd0, 32'd0)); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin regs[i] = 32'd0; mem[i] = 8'd0; end
    bus.tx_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_counters();
    test_regs_mem();
    test_toggle();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
